// File: rtl/aes_pkg.sv
// Shared AES constants, S-box table and GF(2^8) helpers.
// Used by the key schedule and by the round datapath.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        IDLE,
        EMIT
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES S-box lookup.
// Shared between key expansion and SubBytes.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import aes_pkg::*;

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion, one round key per handshake.
// rk_out comes straight from the key register.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KEY_W-1:0]     key_in,
    output logic                 busy,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [KEY_W-1:0]     rk_out,
    output logic [3:0]           rk_idx,
    output logic                 done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_e          r_state;
    logic [KEY_W-1:0]   r_key;
    logic [3:0]         r_idx;
    logic [7:0]         r_rcon;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    logic [WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3;
    logic [WORD_W-1:0]  w_rot, w_sub, w_t;
    logic [WORD_W-1:0]  w_w4, w_w5, w_w6, w_w7;
    logic [KEY_W-1:0]   w_next;
    logic               w_xfer;
    logic               w_last;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_t    = w_sub ^ {r_rcon, 24'h0};
    assign w_w4   = w_w0 ^ w_t;
    assign w_w5   = w_w1 ^ w_w4;
    assign w_w6   = w_w2 ^ w_w5;
    assign w_w7   = w_w3 ^ w_w6;
    assign w_next = {w_w4, w_w5, w_w6, w_w7};

    assign w_xfer = r_valid & rk_ready;
    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_rcon  <= RCON_INIT;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_key   <= key_in;
                        r_idx   <= '0;
                        r_rcon  <= RCON_INIT;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_xfer && w_last) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_xfer) begin
                        r_key  <= w_next;
                        r_idx  <= r_idx + 4'd1;
                        r_rcon <= xtime(r_rcon);
                    end
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign rk_valid = r_valid;
    assign rk_out   = r_key;
    assign rk_idx   = r_idx;
    assign done     = r_done;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule (NR=10 and NR=1 builds).
// Expected round keys are the FIPS-197 and all-zero-key expansions.
module tb_aes_key_schedule;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         start1;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         ready1;

    logic         busy, rk_valid, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;

    logic         busy1, valid1, done1;
    logic [127:0] out1;
    logic [3:0]   idx1;

    int n_cmp;
    int n_err;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes_key_schedule #(.NR(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    aes_key_schedule #(.NR(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .key_in   (key_in),
        .busy     (busy1),
        .rk_valid (valid1),
        .rk_ready (ready1),
        .rk_out   (out1),
        .rk_idx   (idx1),
        .done     (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_key(input string tag, input int i,
                           input logic [127:0] exp);
        chk($sformatf("%s_idx%0d", tag, i), 128'(rk_idx), 128'(i));
        chk($sformatf("%s_key%0d", tag, i), rk_out, exp);
        chk($sformatf("%s_vld%0d", tag, i), 128'(rk_valid), 128'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk(tag, 128'(done), 128'd1);
    endtask

    task automatic kick(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic full_stream(input string tag);
        kick(FIPS_KEY);
        chk_key(tag, 0, FIPS[0]);
        chk({tag, "_busy"}, 128'(busy), 128'd1);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk_key(tag, i, FIPS[i]);
            chk($sformatf("%s_nodone%0d", tag, i), 128'(done), 128'd0);
        end
        step();
        chk({tag, "_done"}, 128'(done), 128'd1);
        chk({tag, "_vld_off"}, 128'(rk_valid), 128'd0);
        chk({tag, "_busy_off"}, 128'(busy), 128'd0);
        chk({tag, "_hold_key"}, rk_out, FIPS[10]);
        chk({tag, "_hold_idx"}, 128'(rk_idx), 128'd10);
        step();
        chk({tag, "_done_1cyc"}, 128'(done), 128'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        start1   = 1'b0;
        key_in   = '0;
        rk_ready = 1'b1;
        ready1   = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_vld", 128'(rk_valid), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_key", rk_out, 128'd0);
        chk("rst_idx", 128'(rk_idx), 128'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // FIPS stream, with a stray start/key while busy
        kick(FIPS_KEY);
        chk_key("fips", 0, FIPS[0]);
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) begin
                start  = 1'b1;
                key_in = {4{32'hdeadbeef}};
            end
            step();
            start = 1'b0;
            chk_key("fips", i, FIPS[i]);
            chk($sformatf("fips_busy%0d", i), 128'(busy), 128'd1);
        end
        step();
        chk("fips_done", 128'(done), 128'd1);
        chk("fips_vld_off", 128'(rk_valid), 128'd0);
        step();
        chk("fips_done_1cyc", 128'(done), 128'd0);

        // all-zero key
        kick(128'd0);
        chk_key("zero", 0, 128'd0);
        step();
        chk_key("zero", 1, 128'h62636363626363636263636362636363);
        step();
        chk_key("zero", 2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
        drain("zero_drain");
        step();

        // backpressure at idx3
        kick(FIPS_KEY);
        step();
        step();
        step();
        chk_key("bp", 3, FIPS[3]);
        rk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_key("bp_hold", 3, FIPS[3]);
        end
        rk_ready = 1'b1;
        step();
        chk_key("bp", 4, FIPS[4]);
        step();
        chk_key("bp", 5, FIPS[5]);
        drain("bp_drain");
        step();

        // async reset at idx5
        kick(FIPS_KEY);
        for (int i = 0; i < 5; i++) step();
        chk_key("mid", 5, FIPS[5]);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 128'(rk_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_key", rk_out, 128'd0);
        chk("mid_rst_idx", 128'(rk_idx), 128'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mid_idle_vld", 128'(rk_valid), 128'd0);
        full_stream("restart");

        // NR=1 build
        key_in = FIPS_KEY;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("nr1_idx0", 128'(idx1), 128'd0);
        chk("nr1_key0", out1, FIPS[0]);
        chk("nr1_vld0", 128'(valid1), 128'd1);
        step();
        chk("nr1_idx1", 128'(idx1), 128'd1);
        chk("nr1_key1", out1, FIPS[1]);
        chk("nr1_vld1", 128'(valid1), 128'd1);
        chk("nr1_nodone", 128'(done1), 128'd0);
        step();
        chk("nr1_done", 128'(done1), 128'd1);
        chk("nr1_vld_off", 128'(valid1), 128'd0);
        step();
        chk("nr1_done_1cyc", 128'(done1), 128'd0);
        chk("nr1_still_off", 128'(valid1), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
